// File: rtl/stream_demux_pkg.sv
// Shared constants for the registered 1-to-NCH stream demultiplexer.
package stream_demux_pkg;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

endpackage

// File: rtl/stream_demux_if.sv
// Producer-side and consumer-side handshake bundle of stream_demux.
interface stream_demux_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 8,
    parameter int SELW  = $clog2(NCH)
);

    logic [WIDTH-1:0]     in_data;
    logic [SELW-1:0]      in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*WIDTH-1:0] out_data;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/demux_out_slot.sv
// One-entry output register with load/drain handshake.
module demux_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             free
);

    // A draining slot can take a new word in the same cycle.
    assign free = ~valid | ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NCH stream demultiplexer, addressed or round-robin.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 8,
    parameter int SELW  = $clog2(NCH),
    parameter int CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    stream_demux_if.slave   bus,
    output logic [SELW-1:0] rr_ptr,
    output logic [CNTW-1:0] drop_cnt
);

    logic [SELW-1:0]      target;
    logic                 in_range;
    logic                 tgt_free;
    logic                 accept;
    logic                 drop;
    logic [NCH-1:0]       load;
    logic [NCH-1:0]       free;
    logic [NCH-1:0]       valid_w;
    logic [NCH*WIDTH-1:0] data_w;

    assign target   = (mode == MODE_RR) ? rr_ptr : bus.in_sel;
    assign in_range = {1'b0, target} < (SELW+1)'(NCH);

    always_comb begin
        tgt_free = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (target == SELW'(k)) begin
                tgt_free = free[k];
            end
        end
    end

    // Out-of-range words are swallowed, so they never stall the producer.
    assign bus.in_ready = ~rst & tgt_free;
    assign accept       = bus.in_valid & bus.in_ready;
    assign drop         = accept & ~in_range;

    always_comb begin
        load = '0;
        for (int k = 0; k < NCH; k++) begin
            load[k] = accept & (target == SELW'(k));
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_out_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[k]),
            .din   (bus.in_data),
            .ready (bus.out_ready[k]),
            .valid (valid_w[k]),
            .dout  (data_w[k*WIDTH +: WIDTH]),
            .free  (free[k])
        );
    end

    assign bus.out_valid = valid_w;
    assign bus.out_data  = data_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept && mode == MODE_RR) begin
            if (rr_ptr == SELW'(NCH - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= rr_ptr + SELW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench: an 8-channel and a 5-channel (2-bit drop counter) instance.
module tb_stream_demux;

    logic clk;
    logic rst;
    logic mode8;
    logic mode5;
    logic [2:0] rr8;
    logic [2:0] rr5;
    logic [7:0] dc8;
    logic [1:0] dc5;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q8[8][$];
    logic [7:0] q5[5][$];

    stream_demux_if #(.WIDTH(8), .NCH(8)) i8 ();
    stream_demux_if #(.WIDTH(8), .NCH(5)) i5 ();

    stream_demux #(.WIDTH(8), .NCH(8), .CNTW(8)) dut8 (
        .clk(clk), .rst(rst), .mode(mode8), .bus(i8),
        .rr_ptr(rr8), .drop_cnt(dc8)
    );

    stream_demux #(.WIDTH(8), .NCH(5), .CNTW(2)) dut5 (
        .clk(clk), .rst(rst), .mode(mode5), .bus(i5),
        .rr_ptr(rr5), .drop_cnt(dc5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid&ready seen between edges is one transfer.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                if (i8.out_valid[k] && i8.out_ready[k]) begin
                    if (q8[k].size() == 0) begin
                        chk($sformatf("unexpected8_ch%0d", k), 64'(i8.out_data[k*8 +: 8]), 64'hx);
                    end else begin
                        chk($sformatf("data8_ch%0d", k), 64'(i8.out_data[k*8 +: 8]), 64'(q8[k].pop_front()));
                    end
                end
            end
            for (int k = 0; k < 5; k++) begin
                if (i5.out_valid[k] && i5.out_ready[k]) begin
                    if (q5[k].size() == 0) begin
                        chk($sformatf("unexpected5_ch%0d", k), 64'(i5.out_data[k*8 +: 8]), 64'hx);
                    end else begin
                        chk($sformatf("data5_ch%0d", k), 64'(i5.out_data[k*8 +: 8]), 64'(q5[k].pop_front()));
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send8(input logic md, input logic [2:0] sel,
                         input logic [7:0] d, input int ch, output int waited);
        waited = 0;
        mode8 = md;
        i8.in_sel = sel;
        i8.in_data = d;
        i8.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (i8.in_ready) break;
            waited++;
            if (waited > 50) break;
        end
        if (waited > 50) begin
            chk("timeout8", 64'(waited), 64'(0));
        end else if (ch >= 0) begin
            q8[ch].push_back(d);
        end
        @(posedge clk);
        #1;
        i8.in_valid = 1'b0;
    endtask

    task automatic send5(input logic md, input logic [2:0] sel,
                         input logic [7:0] d, input int ch, output int waited);
        waited = 0;
        mode5 = md;
        i5.in_sel = sel;
        i5.in_data = d;
        i5.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (i5.in_ready) break;
            waited++;
            if (waited > 50) break;
        end
        if (waited > 50) begin
            chk("timeout5", 64'(waited), 64'(0));
        end else if (ch >= 0) begin
            q5[ch].push_back(d);
        end
        @(posedge clk);
        #1;
        i5.in_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int w;
    int left;
    logic [7:0] rr_exp5 [7];
    logic [1:0] dc_exp [5];

    initial begin
        rr_exp5 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1};
        dc_exp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b1;
        mode8 = 1'b0;
        mode5 = 1'b0;
        i8.in_data = '0; i8.in_sel = '0; i8.in_valid = 1'b0; i8.out_ready = '0;
        i5.in_data = '0; i5.in_sel = '0; i5.in_valid = 1'b0; i5.out_ready = '0;
        step();
        step();
        @(negedge clk);
        chk("rst_out_valid", 64'(i8.out_valid), 64'(0));
        chk("rst_out_data", i8.out_data, 64'(0));
        chk("rst_rr_ptr", 64'(rr8), 64'(0));
        chk("rst_drop_cnt", 64'(dc8), 64'(0));
        chk("rst_in_ready", 64'(i8.in_ready), 64'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(i8.in_ready), 64'(1));
        step();

        // Addressed word to channel 5, held by the consumer.
        send8(1'b0, 3'd5, 8'hA5, 5, w);
        @(negedge clk);
        chk("addr_out_valid", 64'(i8.out_valid), 64'h20);
        chk("addr_out_data", i8.out_data, 64'h0000_A500_0000_0000);
        chk("addr_rr_ptr", 64'(rr8), 64'(0));
        chk("addr_drop_cnt", 64'(dc8), 64'(0));
        step();
        i8.out_ready = 8'h20;
        step();
        i8.out_ready = 8'h00;

        // Back-pressure on channel 2 must not block channel 6.
        send8(1'b0, 3'd2, 8'h22, 2, w);
        i8.in_sel = 3'd2;
        i8.in_data = 8'h33;
        i8.in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_c1", 64'(i8.in_ready), 64'(0));
        @(negedge clk);
        chk("bp_in_ready_c2", 64'(i8.in_ready), 64'(0));
        chk("bp_hold_data", 64'(i8.out_data[23:16]), 64'h22);
        step();
        send8(1'b0, 3'd6, 8'h66, 6, w);
        chk("bp_ch6_wait", 64'(w), 64'(0));
        i8.out_ready = 8'hFF;
        send8(1'b0, 3'd2, 8'h33, 2, w);
        step();
        step();

        // Full-rate pass-through on channel 3.
        for (int i = 0; i < 16; i++) begin
            send8(1'b0, 3'd3, 8'(8'h30 + i), 3, w);
            chk($sformatf("fr_wait_%0d", i), 64'(w), 64'(0));
        end
        step();
        step();
        left = 0;
        for (int k = 0; k < 8; k++) left += q8[k].size();
        chk("fr_drained", 64'(left), 64'(0));
        chk("fr_rr_hold", 64'(rr8), 64'(0));

        // Round-robin wrap on the 5-channel instance; in_sel is ignored.
        i5.out_ready = 5'h1F;
        for (int i = 0; i < 7; i++) begin
            send5(1'b1, 3'd7, 8'(8'h10 + i), int'(rr_exp5[i]), w);
            chk($sformatf("rr_wait_%0d", i), 64'(w), 64'(0));
        end
        chk("rr_ptr_end", 64'(rr5), 64'(2));

        // Out-of-range select: accepted, discarded, counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            send5(1'b0, 3'd6, 8'(8'hE0 + i), -1, w);
            chk($sformatf("drop_wait_%0d", i), 64'(w), 64'(0));
            chk($sformatf("drop_cnt_%0d", i), 64'(dc5), 64'(dc_exp[i]));
            chk($sformatf("drop_valid_%0d", i), 64'(i5.out_valid), 64'(0));
        end
        chk("drop_rr_hold", 64'(rr5), 64'(2));
        step();
        left = 0;
        for (int k = 0; k < 5; k++) left += q5[k].size();
        chk("rr_drained", 64'(left), 64'(0));

        // Reset mid-operation with three full channels and rr_ptr=3.
        i8.out_ready = 8'h00;
        send8(1'b1, 3'd0, 8'hC0, 0, w);
        send8(1'b1, 3'd0, 8'hC1, 1, w);
        send8(1'b1, 3'd0, 8'hC2, 2, w);
        chk("pre_rst_rr", 64'(rr8), 64'(3));
        chk("pre_rst_valid", 64'(i8.out_valid), 64'h07);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) q8[k].delete();
        @(negedge clk);
        chk("mid_rst_in_ready8", 64'(i8.in_ready), 64'(0));
        chk("mid_rst_in_ready5", 64'(i5.in_ready), 64'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid8", 64'(i8.out_valid), 64'(0));
        chk("post_rst_rr8", 64'(rr8), 64'(0));
        chk("post_rst_rr5", 64'(rr5), 64'(0));
        chk("post_rst_dc5", 64'(dc5), 64'(0));
        chk("post_rst_ready8", 64'(i8.in_ready), 64'(1));

        step();
        left = 0;
        for (int k = 0; k < 8; k++) left += q8[k].size();
        for (int k = 0; k < 5; k++) left += q5[k].size();
        chk("end_queues_empty", 64'(left), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
